// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and constants shared by the UART tx/rx pair.
// Parity support in uart_tx is selected with UART_TX_PARITY_EN.
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF  = 16;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; bit_tick marks the last clock of a bit.
// Held at zero while clear is high so the first period is always full length.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  assign bit_tick = !clear && (cnt == div - ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: fifo-fed UART serializer, start + DATA_W LSB-first + stop bits.
// Define UART_TX_PARITY_EN to add the parity_odd input and a parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic [DIV_W-1:0]  baud_div,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd,
`endif
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CW = $clog2(DATA_W + STOP_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam logic [CW-1:0] CONE      = CW'(1);

  uart_state_e       state;
  uart_state_e       state_nx;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bitcnt;
  logic [DIV_W-1:0]  div_q;
  logic              baud_clr;
  logic              bit_tick;

`ifdef UART_TX_PARITY_EN
  logic par_q;
`endif

  assign baud_clr = (state == IDLE) || (state == FETCH);
  assign busy     = (state != IDLE);

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clr),
    .div     (div_q),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    tx         = IDLE_LEVEL;
    tx_done    = 1'b0;
    unique case (state)
      IDLE: begin
        // reset gates the pop so no byte leaves the fifo while held
        if (tx_en && !fifo_empty && !reset) begin
          fifo_rd_en = 1'b1;
          state_nx   = FETCH;
        end
      end
      FETCH: begin
        state_nx = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_tick) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        tx = shreg[0];
        if (bit_tick && bitcnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = par_q;
        if (bit_tick) begin
          state_nx = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick && bitcnt == LAST_STOP) begin
          tx_done  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      bitcnt <= '0;
      div_q  <= '0;
    end else begin
      case (state)
        FETCH: begin
          shreg  <= fifo_data;
          bitcnt <= '0;
          div_q  <= (baud_div == '0) ? DIV_W'(1) : baud_div;
        end
        DATA: begin
          if (bit_tick) begin
            shreg  <= shreg >> 1;
            bitcnt <= (bitcnt == LAST_DATA) ? '0 : bitcnt + CONE;
          end
        end
        STOP: begin
          if (bit_tick) begin
            bitcnt <= bitcnt + CONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (state == FETCH) begin
      par_q <= (^fifo_data) ^ parity_odd;
    end
  end
`endif

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmit serializer; sits directly downstream of the TX fifo in the APB-UART path.
- Pops bytes from the fifo read port and drives the serial `tx` line: 8N1 by default, stop-bit count and parity configurable.
- Bit timing comes from a programmable clocks-per-bit divisor supplied by the APB register block.

Parameters:
- DATA_W, 8, data bits per frame (matches fifo width).
- DIV_W, 16, width of the baud divisor input.
- STOP_BITS, 1, stop bits per frame; legal values are 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_en  input  1  transmitter enable; gates fetching of new bytes.
- baud_div  input  DIV_W  clocks per bit; 0 is treated as 1.
- fifo_empty  input  1  fifo Empty flag.
- fifo_data  input  DATA_W  fifo dataOut.
- fifo_rd_en  output  1  fifo readEn; one-cycle pop strobe.
- tx  output  1  serial line, idle high.
- busy  output  1  high whenever state != IDLE.
- tx_done  output  1  one-cycle pulse at end of the stop period.

Behaviour:
- Clock and reset: one clock (`clk`); reset is asynchronous, active-high (`reset`).
- Reset values: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE; bit counter, baud counter and shift register all 0.
- Fifo contract: fifo_data is valid on the cycle after fifo_rd_en is asserted (registered read).
- fifo_rd_en is never asserted while fifo_empty=1.
- States: IDLE -> FETCH -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1.
  - If tx_en=1 and fifo_empty=0: assert fifo_rd_en for exactly one cycle, go to FETCH.
- FETCH: one cycle, tx=1.
  - Load fifo_data into the shift register.
  - Latch baud_div (0 -> 1) into the frame divisor; clear the baud counter.
  - Go to START.
- Bit period: the baud counter runs 0..div-1; the bit advances when the counter equals div-1. Each bit lasts exactly div clocks.
- START: tx=0 for one bit period.
- DATA: DATA_W bits, LSB first, one bit period each; shift right on each bit boundary.
- STOP: tx=1 for STOP_BITS bit periods.
  - On its final cycle: pulse tx_done, go to IDLE.
- Back-to-back frames: IDLE(1) + FETCH(1) give exactly 2 idle-high clocks between a stop bit and the next start bit.
- Frame length from start-bit edge to end of stop: (1 + DATA_W + STOP_BITS [+1 parity]) * div clocks.
- baud_div changes mid-frame: no effect until the next FETCH.
- tx_en deasserted mid-frame: the current frame completes normally; no further fetch. tx_en has no effect on a frame already in progress.
- fifo_empty rising mid-frame: no effect; it is only sampled in IDLE.
- Reset mid-frame: tx returns to 1 immediately (async); the frame is abandoned and the popped byte is lost; no tx_done.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 bit), sampled at FETCH.
  - Inserts a PARITY state between DATA and STOP, lasting one bit period.
  - tx = XOR of the data bits (even parity), inverted when parity_odd=1.
- Undefined:
  - No parity_odd port, no PARITY state; DATA goes straight to STOP.

Decomposition:
- Package uart_pkg:
  - State encoding: IDLE, FETCH, START, DATA, PARITY, STOP.
  - Constants DATA_W_DEF=8 and DIV_W_DEF=16, plus the IDLE_LEVEL=1 constant.
  - Shared with the future uart_rx.
- Sub-module uart_baud_gen:
  - Inputs: clk, reset, clear, div.
  - Output: bit_tick, pulsed on the last clock of each bit period.
  - Reusable by uart_rx at 16x oversampling.

Test Plan:
1. Reset: assert reset with the fifo non-empty -> tx=1, fifo_rd_en=0, busy=0 throughout; no pop.
2. Single byte: baud_div=4, fifo holds 8'hA5 -> one fifo_rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks (40 clocks total); tx_done pulses once; busy falls the next cycle.
3. Burst: fifo holds 8'd255, 8'd165, 8'd109 with baud_div=2 -> exactly 3 rd_en pulses, bytes serialized in order, exactly 2 idle clocks between frames, fifo_empty=1 afterwards with tx=1.
4. Empty and disabled:
   - fifo_empty=1 for 200 clocks -> no rd_en, tx=1.
   - tx_en dropped at data bit 3 -> that frame completes; no further pops.
5. Reset mid-frame: reset asserted during data bit 5 -> tx=1 on the same edge; state=IDLE; after release, the next byte is fetched normally.
6. Parity (UART_TX_PARITY_EN defined): 8'hA5 with parity_odd=0 -> parity bit 0; with parity_odd=1 -> parity bit 1; frame length 11*div clocks.
